// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding a register file: buffers (addr, data) writes,
// drains them in order, and reports whether an address has a write pending.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    upstream write request handshake
//   in_addr, in_data     request target register and data
//   rf_wren/waddr/wdata  registered write port to the register file
//   drain_en             allows the head entry to be popped this cycle
//   chk_addr/chk_pending probe for queued or in-flight writes to an address
//   occupancy            registered entry count
//
// Compile-time option: WBQ_COALESCE_EN merges a request into the tail entry
// when it targets the same register (data overwrite, no new entry).
module regfile_wb_queue #(
    parameter int Dwidth = 8,
    parameter int Awidth = 2,
    parameter int Depth  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [Awidth-1:0]        in_addr,
    input  logic [Dwidth-1:0]        in_data,
    output logic                     rf_wren,
    output logic [Awidth-1:0]        rf_waddr,
    output logic [Dwidth-1:0]        rf_wdata,
    input  logic                     drain_en,
    input  logic [Awidth-1:0]        chk_addr,
    output logic                     chk_pending,
    output logic [$clog2(Depth):0]   occupancy
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    logic [Awidth-1:0] addr_q [Depth];
    logic [Dwidth-1:0] data_q [Depth];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              nonempty;
    logic              pop;
    logic              push;
    logic              coal;
    logic [PW-1:0]     off;

    assign full     = (occupancy == CW'(Depth));
    assign nonempty = (occupancy != '0);
    assign pop      = rst_n && drain_en && nonempty;

`ifdef WBQ_COALESCE_EN
    logic [PW-1:0] tail_idx;
    assign tail_idx = wr_ptr - PW'(1);
    // A lone entry being popped this edge cannot absorb new data.
    assign coal = rst_n && in_valid && nonempty
                  && (addr_q[tail_idx] == in_addr)
                  && !(pop && occupancy == CW'(1));
`else
    assign coal = 1'b0;
`endif

    assign in_ready = rst_n && (!full || coal);
    assign push     = in_valid && in_ready && !coal;

    // Storage carries no reset; occupancy alone defines which entries live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
`ifdef WBQ_COALESCE_EN
        else if (coal) begin
            data_q[tail_idx] <= in_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            rf_wren   <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            occupancy <= occupancy + CW'(push) - CW'(pop);
            rf_wren   <= pop;
            if (pop) begin
                rf_waddr <= addr_q[rd_ptr];
                rf_wdata <= data_q[rd_ptr];
            end
        end
    end

    // An entry is live when its distance from the head is below occupancy.
    always_comb begin
        off         = '0;
        chk_pending = rf_wren && (rf_waddr == chk_addr);
        for (int i = 0; i < Depth; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < occupancy) && (addr_q[i] == chk_addr))
                chk_pending = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue (default parameters).
// Follows WBQ_COALESCE_EN so expectations match the build under test.
module tb_regfile_wb_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_addr;
    logic [7:0] in_data;
    logic       rf_wren;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       drain_en;
    logic [1:0] chk_addr;
    logic       chk_pending;
    logic [2:0] occupancy;

    int n_vec = 0;
    int n_err = 0;

`ifdef WBQ_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    regfile_wb_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .rf_wren    (rf_wren),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .drain_en   (drain_en),
        .chk_addr   (chk_addr),
        .chk_pending(chk_pending),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_chk(input string tag, input logic en,
                          input logic [1:0] a, input logic [7:0] d);
        chk({tag, "_wren"}, 32'(rf_wren), 32'(en));
        if (en) begin
            chk({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
            chk({tag, "_wdata"}, 32'(rf_wdata), 32'(d));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b0;
        chk_addr = '0;
        tick();
        tick();
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_wren",  32'(rf_wren),   32'd0);
        chk("rst_waddr", 32'(rf_waddr),  32'd0);
        chk("rst_wdata", 32'(rf_wdata),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);

        // single write, one cycle after accept
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_addr  = 2'd1;
        in_data  = 8'h11;
        tick();
        in_valid = 1'b0;
        chk("s_occ1", 32'(occupancy), 32'd1);
        wr_chk("s_n", 1'b0, 2'd0, 8'h00);
        tick();
        wr_chk("s_n1", 1'b1, 2'd1, 8'h11);
        chk("s_occ0", 32'(occupancy), 32'd0);
        tick();
        wr_chk("s_n2", 1'b0, 2'd0, 8'h00);
        chk("s_hold_a", 32'(rf_waddr), 32'd1);
        chk("s_hold_d", 32'(rf_wdata), 32'h11);

        // fill to full with 5 back-to-back requests
        drain_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_addr  = 2'(k);
            in_data  = 8'(8'h20 + k);
            #1;
            chk($sformatf("f_ready%0d", k), 32'(in_ready), 32'(k < 4));
            tick();
        end
        in_valid = 1'b0;
        chk("f_occ4", 32'(occupancy), 32'd4);
        chk_addr = 2'd2;
        #1;
        chk("f_pend2", 32'(chk_pending), 32'd1);
        drain_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            wr_chk($sformatf("f_d%0d", k), 1'b1, 2'(k), 8'(8'h20 + k));
            chk($sformatf("f_occ_d%0d", k), 32'(occupancy), 32'(3 - k));
        end
        tick();
        wr_chk("f_idle", 1'b0, 2'd0, 8'h00);

        // full + pop + request on same edge: no push that edge
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_addr  = 2'(k);
            in_data  = 8'(8'h30 + k);
            tick();
        end
        drain_en = 1'b1;
        in_addr  = 2'd1;
        in_data  = 8'h44;
        #1;
        chk("fp_ready0", 32'(in_ready), 32'd0);
        tick();
        chk("fp_occ3", 32'(occupancy), 32'd3);
        wr_chk("fp_w0", 1'b1, 2'd0, 8'h30);
        chk("fp_ready1", 32'(in_ready), 32'd1);
        drain_en = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("fp_occ4", 32'(occupancy), 32'd4);
        drain_en = 1'b1;
        tick();
        wr_chk("fp_w1", 1'b1, 2'd1, 8'h31);
        tick();
        wr_chk("fp_w2", 1'b1, 2'd2, 8'h32);
        tick();
        wr_chk("fp_w3", 1'b1, 2'd3, 8'h33);
        tick();
        wr_chk("fp_w4", 1'b1, 2'd1, 8'h44);
        tick();
        wr_chk("fp_idle", 1'b0, 2'd0, 8'h00);
        chk("fp_occ0", 32'(occupancy), 32'd0);

        // pending probe
        drain_en = 1'b0;
        in_valid = 1'b1;
        in_addr  = 2'd2;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        chk_addr = 2'd2;
        #1;
        chk("p_q2", 32'(chk_pending), 32'd1);
        chk_addr = 2'd3;
        #1;
        chk("p_q3", 32'(chk_pending), 32'd0);
        chk_addr = 2'd2;
        drain_en = 1'b1;
        tick();
        wr_chk("p_w", 1'b1, 2'd2, 8'h55);
        chk("p_fly2", 32'(chk_pending), 32'd1);
        tick();
        chk("p_done_wren", 32'(rf_wren), 32'd0);
        chk("p_done2", 32'(chk_pending), 32'd0);

        // reset while busy
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_addr  = 2'(k);
            in_data  = 8'(8'h60 + k);
            tick();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        wr_chk("r_w0", 1'b1, 2'd0, 8'h60);
        chk("r_occ3", 32'(occupancy), 32'd3);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_addr  = 2'd1;
        in_data  = 8'h77;
        #1;
        chk("r_ready0", 32'(in_ready), 32'd0);
        tick();
        chk("r_occ0", 32'(occupancy), 32'd0);
        chk("r_wren0", 32'(rf_wren), 32'd0);
        chk("r_waddr0", 32'(rf_waddr), 32'd0);
        chk("r_wdata0", 32'(rf_wdata), 32'd0);
        chk("r_ready_in", 32'(in_ready), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("r_ready1", 32'(in_ready), 32'd1);
        tick();
        chk("r_stale1", 32'(rf_wren), 32'd0);
        tick();
        chk("r_stale2", 32'(rf_wren), 32'd0);
        chk("r_occ_after", 32'(occupancy), 32'd0);

        // same-address requests
        drain_en = 1'b0;
        in_valid = 1'b1;
        in_addr  = 2'd3;
        in_data  = 8'h01;
        tick();
        in_data  = 8'h02;
        tick();
        in_valid = 1'b0;
        chk("c_occ", 32'(occupancy), COAL ? 32'd1 : 32'd2);
        drain_en = 1'b1;
        tick();
        wr_chk("c_w0", 1'b1, 2'd3, COAL ? 8'h02 : 8'h01);
        tick();
        wr_chk("c_w1", !COAL, 2'd3, 8'h02);
        tick();
        wr_chk("c_idle", 1'b0, 2'd0, 8'h00);
        chk("c_occ0", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
